color_detect: RTL
=================

// Module: color_detect
// PURPOSE
//  Front end for the TCS3200 colour sensor on the patch-detection path. Steps the sensor filter through
//  red, green, blue and clear, counts sensor_out edges over a fixed gate per filter and classifies the
//  patch. Drives color[1:0] directly into the LED latching stage (1 red, 2 green, 3 blue, 0 none).
//  The output must read 0 whenever detection is disabled, because downstream advances on color==0.
// PARAMETERS
//  GATE_CYCLES    2000  clk cycles per filter counting window
//  SETTLE_CYCLES  100   clk cycles after a filter change before counting starts
//  CNT_W          12    edge-counter width; counts saturate at 2^CNT_W-1
//  MIN_CLEAR      16    minimum clear-filter count for any non-zero colour
//  MARGIN         4     winner must exceed each other RGB count by >= MARGIN; MARGIN >= 1 required
//  CONFIRM        2     consecutive identical frame decisions needed to update color (>= 1)
// PORTS
//  clk_1MHz     in   1      system clock, 1 MHz
//  rst          in   1      synchronous, active-high reset
//  detect_en    in   1      1 = run detection frames; 0 = idle, color forced to 0
//  sensor_out   in   1      TCS3200 OUT, asynchronous square wave
//  s0, s1       out  1      frequency scaling, constant 0/1 (2 %)
//  s2, s3       out  1      filter select: R=00, B=01, C=10, G=11
//  color        out  2      confirmed colour code
//  color_valid  out  1      1-cycle pulse when each frame decision completes
//  busy         out  1      1 whenever the FSM is not IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, counts/candidate/match cleared. color=0, color_valid=0, busy=0, s2/s3=00, s0=0, s1=1.
//  sensor_out: 2-flop synchroniser, then rising-edge detect. Edges are counted only in GATE.
//   Edge counter is saturating (never wraps).
//  FSM: IDLE -> SETTLE -> GATE -> (next filter) SETTLE ... -> DECIDE -> SETTLE (red) while detect_en.
//   Filter order: R, G, B, C. filt_idx 0..3 selects s2/s3 from the same cycle SETTLE is entered.
//   SETTLE holds exactly SETTLE_CYCLES cycles and clears the edge counter.
//   GATE holds exactly GATE_CYCLES cycles. On exit, the count is stored to cnt_r/g/b/c[filt_idx].
//   DECIDE is 1 cycle. A frame is 4*(SETTLE_CYCLES+GATE_CYCLES)+1 cycles; 8401 with defaults.
//  Decision, combinational in DECIDE, compared at CNT_W+1 bits (no overflow):
//   dec = X when cnt_X >= cnt_Y + MARGIN for both other RGB counts Y, and cnt_c >= MIN_CLEAR; else dec = 0.
//  Confirm, registered in DECIDE:
//   If dec == cand: match = min(match+1, CONFIRM). Otherwise cand <= dec and match <= 1.
//   When the resulting match == CONFIRM, color <= cand (this includes cand == 0).
//   color_valid = 1 in the cycle after DECIDE.
//  detect_en low in any state: next cycle FSM=IDLE, color=0, cand=0, match=0, s2/s3=00.
//   The partial frame is discarded.
//  detect_en rising from IDLE: enter SETTLE(R) next cycle.
//   First color update comes CONFIRM frames later (16802 cycles with defaults).
//  rst has priority over all events, including mid-GATE and a simultaneous edge.
// STRUCTURE
//  Shared include color_defs.vh holds:
//   - colour codes COL_NONE/RED/GREEN/BLUE;
//   - filter encodings FILT_R/G/B/C;
//   - FSM state localparams.
//  One sub-module, edge_counter: synchroniser, edge detect and saturating CNT_W counter,
//   with clr and en inputs.
//  Top level: FSM, gate/settle timer, four count registers, decision/confirm logic.
// TESTING
//  1 Red patch: per filter R 10 kHz, G 5 kHz, B 4 kHz, C 20 kHz (counts 20/10/8/40).
//    -> color=1 after 16802 cycles; color_valid pulses every 8401 cycles.
//  2 Dark: all filters 1 kHz (counts 2).
//    -> every decision 0, color stays 0.
//  3 Near tie: R 20, G 18, B 8, C 40 counts.
//    -> dec=0; after previously confirmed green, color falls to 0 after 2 frames.
//  4 Flicker: frames alternate blue/green decisions with CONFIRM=2.
//    -> color never changes from its prior value.
//  5 detect_en dropped mid-GATE(B) while color=3.
//    -> next cycle color=0, busy=0, s2/s3=00; re-enable restarts at SETTLE(R).
//  6 CNT_W=4, sensor 50 kHz on all filters (100 edges/gate).
//    -> all counts 15 (no wrap); dec=0 by MARGIN rule. Also assert rst mid-GATE: all outputs reset next cycle.

Source files
------------

// File: rtl/color_detect_pkg.sv
// Shared colour codes, sensor filter encodings and FSM states for the colour front end.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package color_detect_pkg;

    typedef enum logic [1:0] {
        COL_NONE  = 2'd0,
        COL_RED   = 2'd1,
        COL_GREEN = 2'd2,
        COL_BLUE  = 2'd3
    } color_e;

    // TCS3200 {S2,S3} filter select codes
    localparam logic [1:0] FILT_R = 2'b00;
    localparam logic [1:0] FILT_G = 2'b11;
    localparam logic [1:0] FILT_B = 2'b01;
    localparam logic [1:0] FILT_C = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_DECIDE
    } state_e;

    // Frame order is R, G, B, C; index 0..3 maps onto the sensor's filter codes
    function automatic logic [1:0] filt_sel(input logic [1:0] idx);
        case (idx)
            2'd0:    return FILT_R;
            2'd1:    return FILT_G;
            2'd2:    return FILT_B;
            default: return FILT_C;
        endcase
    endfunction

endpackage

// File: rtl/color_detect_if.sv
// Bundle of the sensor pins, enable and colour result around color_detect.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are free-running levels or single-cycle pulses.
interface color_detect_if;
    logic       detect_en;
    logic       sensor_out;
    logic       s0;
    logic       s1;
    logic       s2;
    logic       s3;
    logic [1:0] color;
    logic       color_valid;
    logic       busy;

    // System side: enables detection and presents the raw sensor wave
    modport master (
        output detect_en, sensor_out,
        input  s0, s1, s2, s3, color, color_valid, busy
    );

    // Detector side
    modport slave (
        input  detect_en, sensor_out,
        output s0, s1, s2, s3, color, color_valid, busy
    );
endinterface

// File: rtl/color_detect_edge_counter.sv
// Synchronises the asynchronous sensor wave, detects rising edges and counts them saturating.
// Latency: 3 cycles from a sensor rising edge to the count increment (2-flop sync + edge flop).
// Backpressure: none; clr has priority over en, count holds at all-ones instead of wrapping.
module color_detect_edge_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic             rise;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser pipeline, edge detect and saturating count update
    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && rise && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/color_detect.sv
// TCS3200 front end: steps R/G/B/C filters, counts edges per gate and classifies the patch colour.
// Latency: one frame is 4*(SETTLE_CYCLES+GATE_CYCLES)+1 cycles; colour changes after CONFIRM agreeing frames.
// Backpressure: none; detect_en low aborts the frame and forces colour 0 on the next cycle.
module color_detect
    import color_detect_pkg::*;
#(
    parameter int GATE_CYCLES   = 2000,
    parameter int SETTLE_CYCLES = 100,
    parameter int CNT_W         = 12,
    parameter int MIN_CLEAR     = 16,
    parameter int MARGIN        = 4,
    parameter int CONFIRM       = 2
) (
    input  logic           clk_1MHz,
    input  logic           rst,
    color_detect_if.slave  bus
);
    localparam int TMR_W   = $clog2(GATE_CYCLES > SETTLE_CYCLES ? GATE_CYCLES : SETTLE_CYCLES);
    localparam int MATCH_W = $clog2(CONFIRM + 1);
    localparam int CW1     = CNT_W + 1;

    localparam logic [TMR_W-1:0]   GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [MATCH_W-1:0] MATCH_FULL  = MATCH_W'(CONFIRM);
    localparam logic [MATCH_W-1:0] MATCH_ONE   = MATCH_W'(1);
    // One extra bit so count + MARGIN can never overflow in the comparison
    localparam logic [CW1-1:0]     MARGIN_X    = CW1'(MARGIN);
    localparam logic [CW1-1:0]     MIN_CLEAR_X = CW1'(MIN_CLEAR);

    state_e               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [1:0]           filt_q, filt_d;
    logic [CNT_W-1:0]     cnt_q [4];
    logic [CNT_W-1:0]     cnt_d [4];
    color_e               cand_q, cand_d, cand_n;
    color_e               color_q, color_d;
    color_e               dec;
    logic [MATCH_W-1:0]   match_q, match_d, match_n;
    logic                 valid_q, valid_d;
    logic [CNT_W-1:0]     edge_cnt;
    logic [CW1-1:0]       r_x, g_x, b_x, c_x;

    color_detect_edge_counter #(.CNT_W(CNT_W)) u_edge_cnt (
        .clk    (clk_1MHz),
        .rst    (rst),
        .sig_in (bus.sensor_out),
        .clr    (state_q == ST_SETTLE),
        .en     (state_q == ST_GATE),
        .cnt    (edge_cnt)
    );

    // Frame classification from the four stored counts, plus the confirm-counter update it implies
    always_comb begin
        r_x = CW1'(cnt_q[0]);
        g_x = CW1'(cnt_q[1]);
        b_x = CW1'(cnt_q[2]);
        c_x = CW1'(cnt_q[3]);
        dec = COL_NONE;
        if (c_x >= MIN_CLEAR_X) begin
            if ((r_x >= g_x + MARGIN_X) && (r_x >= b_x + MARGIN_X)) begin
                dec = COL_RED;
            end else if ((g_x >= r_x + MARGIN_X) && (g_x >= b_x + MARGIN_X)) begin
                dec = COL_GREEN;
            end else if ((b_x >= r_x + MARGIN_X) && (b_x >= g_x + MARGIN_X)) begin
                dec = COL_BLUE;
            end
        end
        if (dec == cand_q) begin
            cand_n  = cand_q;
            match_n = (match_q >= MATCH_FULL) ? MATCH_FULL : match_q + MATCH_ONE;
        end else begin
            cand_n  = dec;
            match_n = MATCH_ONE;
        end
    end

    // Frame sequencer: settle/gate per filter, then a single decide cycle
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        filt_d  = filt_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        match_d = match_q;
        color_d = color_q;
        valid_d = 1'b0;
        if (!bus.detect_en) begin
            state_d = ST_IDLE;
            timer_d = '0;
            filt_d  = '0;
            cand_d  = COL_NONE;
            match_d = '0;
            color_d = COL_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                    timer_d = '0;
                    filt_d  = '0;
                end
                ST_SETTLE: begin
                    if (timer_q == SETTLE_LAST) begin
                        state_d = ST_GATE;
                        timer_d = '0;
                    end
                end
                ST_GATE: begin
                    if (timer_q == GATE_LAST) begin
                        cnt_d[filt_q] = edge_cnt;
                        timer_d       = '0;
                        if (filt_q == 2'd3) begin
                            state_d = ST_DECIDE;
                        end else begin
                            state_d = ST_SETTLE;
                            filt_d  = filt_q + 2'd1;
                        end
                    end
                end
                ST_DECIDE: begin
                    state_d = ST_SETTLE;
                    timer_d = '0;
                    filt_d  = '0;
                    valid_d = 1'b1;
                    cand_d  = cand_n;
                    match_d = match_n;
                    if (match_n == MATCH_FULL) begin
                        color_d = cand_n;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            filt_q  <= '0;
            cnt_q   <= '{default: '0};
            cand_q  <= COL_NONE;
            match_q <= '0;
            color_q <= COL_NONE;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            match_q <= match_d;
            color_q <= color_d;
            valid_q <= valid_d;
        end
    end

    assign bus.s0               = 1'b0;
    assign bus.s1               = 1'b1;
    assign {bus.s2, bus.s3}     = filt_sel(filt_q);
    assign bus.color            = color_q;
    assign bus.color_valid      = valid_q;
    assign bus.busy             = (state_q != ST_IDLE);
endmodule
